protocol_req_arbiter: RTL and testbench
=======================================

PROTOCOL_REQ_ARBITER -- requirements
Module: protocol_req_arbiter

Interface
REQ-001 Parameter CONFIG_DATA_WIDTH, 64, width of request/response data; positive integer.
REQ-002 Parameter CONFIG_ADDR_WIDTH, 32, width of request address; positive integer.
REQ-003 Parameter TIMEOUT_CYCLES, 16, stall cycles before timeout flag; range 2..255.
REQ-004 Port clk_i  input  1  single clock; all logic rising-edge.
REQ-005 Port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 Port req_valid_i  input  3  per-requester valid; bit 0 = AXI4, 1 = CHI, 2 = TileLink.
REQ-007 Port req_ready_o  output  3  per-requester ready; at most one bit high per cycle.
REQ-008 Port req_addr_i  input  3*CONFIG_ADDR_WIDTH  packed addresses; slot i at [i*CONFIG_ADDR_WIDTH +: CONFIG_ADDR_WIDTH].
REQ-009 Port req_data_i  input  3*CONFIG_DATA_WIDTH  packed data; slot i at [i*CONFIG_DATA_WIDTH +: CONFIG_DATA_WIDTH].
REQ-010 Port out_valid_o  output  1  shared downstream port valid (registered).
REQ-011 Port out_ready_i  input  1  downstream ready.
REQ-012 Port out_addr_o  output  CONFIG_ADDR_WIDTH  registered address of granted request.
REQ-013 Port out_data_o  output  CONFIG_DATA_WIDTH  registered data of granted request.
REQ-014 Port out_src_o  output  2  source id of the request on the output (0/1/2).
REQ-015 Port timeout_o  output  1  sticky downstream-stall flag.
REQ-016 Port timeout_clr_i  input  1  clears timeout_o.

Function
REQ-017 FSM states IDLE (output register empty) and BUSY (output register holds one request); out_valid_o = (state == BUSY).
REQ-018 Load condition: state IDLE, or BUSY with out_valid_o && out_ready_i in the same cycle.
REQ-019 On a load cycle with any req_valid_i set, winner = first set bit searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); req_ready_o[winner] = 1 combinationally; all other ready bits 0.
REQ-020 No load condition -> req_ready_o = 3'b000 regardless of req_valid_i.
REQ-021 Accepted request captured into out_addr_o/out_data_o/out_src_o on that edge; out_valid_o high next cycle (latency 1).
REQ-022 After accepting winner w, rr_ptr <= (w+1) mod 3; rr_ptr unchanged when nothing accepted.
REQ-023 Transitions: IDLE->BUSY on accept; BUSY->IDLE on handshake with no accept; BUSY->BUSY on handshake with accept (back-to-back, no bubble) or on stall.
REQ-024 While out_valid_o && !out_ready_i, out_addr_o/out_data_o/out_src_o SHALL stay stable.
REQ-025 Full throughput: with out_ready_i held high and requests pending, one transfer per cycle.
REQ-026 Requesters with valid but not ready SHALL NOT be dropped; they are served in rotation.

Reset
REQ-027 rst_ni low asynchronously forces state IDLE, rr_ptr 0, out_valid_o 0, out_addr_o 0, out_data_o 0, out_src_o 0, timeout_o 0, stall counter 0.
REQ-028 req_ready_o SHALL be 3'b000 while rst_ni low; a request held across reset is re-arbitrated after release.
REQ-029 Reset asserted mid-transfer SHALL discard the held request with no handshake emitted.

Configuration
REQ-030 Macro PROTOCOL_ARB_STALL_WATCHDOG_EN compiles in the stall watchdog.
REQ-031 Defined: 8-bit stall counter increments each cycle out_valid_o && !out_ready_i, clears on handshake or IDLE, saturates at TIMEOUT_CYCLES.
REQ-032 Defined: timeout_o set on the edge the counter reaches TIMEOUT_CYCLES; held until timeout_clr_i; clear has priority over set in the same cycle.
REQ-033 Not defined: counter absent, timeout_o tied 0, timeout_clr_i ignored; arbitration unchanged.

Verification
REQ-034 Reset, all req_valid_i = 0 for 5 cycles -> out_valid_o 0, req_ready_o 3'b000, timeout_o 0.
REQ-035 Only bit 1 valid, addr 32'h2000, data 64'h12345678_9ABCDEF0, out_ready_i 1 -> req_ready_o 3'b010 same cycle; next cycle out_valid_o 1, out_src_o 1, same addr/data.
REQ-036 All three valid continuously, out_ready_i 1 -> out_src_o sequence 0,1,2,0,1,2 on consecutive cycles, no bubbles.
REQ-037 Bit 2 accepted, out_ready_i 0 for 10 cycles -> outputs stable, req_ready_o 3'b000, then single handshake when ready returns.
REQ-038 Watchdog built, TIMEOUT_CYCLES 16, out_ready_i 0 for 20 cycles -> timeout_o high from stall cycle 16, stays high after handshake until timeout_clr_i pulsed; without macro timeout_o never high.
REQ-039 rst_ni pulsed low while BUSY and stalled -> out_valid_o 0 immediately; after release first grant goes to lowest-index valid requester.

Source files
------------

// File: rtl/protocol_req_arbiter.sv
// Three-requester (AXI4 / CHI / TileLink) round-robin arbiter feeding one registered output slot.
// Optional stall watchdog compiled in with `define PROTOCOL_ARB_STALL_WATCHDOG_EN.
module protocol_req_arbiter #(
    parameter int CONFIG_DATA_WIDTH = 64,
    parameter int CONFIG_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [2:0]                     req_valid_i,
    output logic [2:0]                     req_ready_o,
    input  logic [3*CONFIG_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [3*CONFIG_DATA_WIDTH-1:0] req_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [CONFIG_ADDR_WIDTH-1:0]   out_addr_o,
    output logic [CONFIG_DATA_WIDTH-1:0]   out_data_o,
    output logic [1:0]                     out_src_o,
    output logic                           timeout_o,
    input  logic                           timeout_clr_i
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [1:0]                     r_rr_ptr;
    logic [CONFIG_ADDR_WIDTH-1:0]   r_out_addr;
    logic [CONFIG_DATA_WIDTH-1:0]   r_out_data;
    logic [1:0]                     r_out_src;

    logic                           w_any;
    logic [1:0]                     w_winner;
    logic [2:0]                     w_grant;
    logic                           w_accept;
    logic                           w_load;
    logic                           w_handshake;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // Scan from the lowest priority upward so the last match is the one nearest rr_ptr.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_any    = 1'b0;
        w_winner = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req_valid_i[mod3_add(r_rr_ptr, 2'(k))]) begin
                w_any    = 1'b1;
                w_winner = mod3_add(r_rr_ptr, 2'(k));
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_handshake && !w_accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Output logic: the slot can load when empty or when it drains this very cycle.
    always_comb begin
        out_valid_o = (r_state == ST_BUSY);
        w_handshake = out_valid_o && out_ready_i;
        w_load      = !out_valid_o || out_ready_i;
        w_grant     = 3'b000;
        if (rst_ni && w_load && w_any) begin
            w_grant = 3'b001 << w_winner;
        end
    end

    assign req_ready_o = w_grant;
    assign w_accept    = |w_grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= 2'd0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_src  <= 2'd0;
        end else if (w_accept) begin
            r_rr_ptr   <= mod3_add(w_winner, 2'd1);
            r_out_addr <= req_addr_i[w_winner*CONFIG_ADDR_WIDTH +: CONFIG_ADDR_WIDTH];
            r_out_data <= req_data_i[w_winner*CONFIG_DATA_WIDTH +: CONFIG_DATA_WIDTH];
            r_out_src  <= w_winner;
        end
    end

    assign out_addr_o = r_out_addr;
    assign out_data_o = r_out_data;
    assign out_src_o  = r_out_src;

`ifdef PROTOCOL_ARB_STALL_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_stall_cnt;
    logic       r_timeout;
    logic       w_stall;
    logic       w_timeout_set;

    assign w_stall       = out_valid_o && !out_ready_i;
    assign w_timeout_set = w_stall && (r_stall_cnt == TIMEOUT_LIMIT - 8'd1);

    // Counter saturates at the limit; any non-stall cycle (handshake or idle) clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= 8'd0;
        end else if (w_stall) begin
            if (r_stall_cnt != TIMEOUT_LIMIT) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end else begin
            r_stall_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timeout <= 1'b0;
        end else if (timeout_clr_i) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_set) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_timeout_clr;

    assign w_unused_timeout_clr = timeout_clr_i;
    assign timeout_o            = 1'b0;
`endif

endmodule

// File: tb/tb_protocol_req_arbiter.sv
// Scoreboard bench for protocol_req_arbiter: a cycle-level reference model predicts grants and
// pushes expected transfers; an independent monitor pops them on every downstream handshake.
module tb_protocol_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 16;
`ifdef PROTOCOL_ARB_STALL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [2:0]      req_valid_i;
    logic [2:0]      req_ready_o;
    logic [3*AW-1:0] req_addr_i;
    logic [3*DW-1:0] req_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [AW-1:0]   out_addr_o;
    logic [DW-1:0]   out_data_o;
    logic [1:0]      out_src_o;
    logic            timeout_o;
    logic            timeout_clr_i;

    protocol_req_arbiter #(
        .CONFIG_DATA_WIDTH(DW),
        .CONFIG_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_addr_o   (out_addr_o),
        .out_data_o   (out_data_o),
        .out_src_o    (out_src_o),
        .timeout_o    (timeout_o),
        .timeout_clr_i(timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    src;
    } xfer_t;

    xfer_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy flag, rotating priority pointer, stall counter, sticky flag.
    int    m_ptr = 0;
    bit    m_occ = 1'b0;
    int    m_cnt = 0;
    bit    m_to  = 1'b0;

    always @(negedge clk_i) begin : model
        logic [2:0] exp_ready;
        bit         found;
        int         c;
        xfer_t      x;
        if (!rst_ni) begin
            check("reset_req_ready", 64'(req_ready_o), 64'd0);
            check("reset_out_valid", 64'(out_valid_o), 64'd0);
            check("reset_timeout", 64'(timeout_o), 64'd0);
            m_ptr = 0;
            m_occ = 1'b0;
            m_cnt = 0;
            m_to  = 1'b0;
            sb_q.delete();
        end else begin
            check("out_valid", 64'(out_valid_o), 64'(m_occ));
            check("timeout", 64'(timeout_o), 64'(m_to));
            exp_ready = 3'b000;
            found     = 1'b0;
            if (!m_occ || out_ready_i) begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_ptr + k) % 3;
                    if (!found && req_valid_i[c]) begin
                        found        = 1'b1;
                        exp_ready[c] = 1'b1;
                        x.addr       = req_addr_i[c*AW +: AW];
                        x.data       = req_data_i[c*DW +: DW];
                        x.src        = 2'(c);
                    end
                end
            end
            check("req_ready", 64'(req_ready_o), 64'(exp_ready));
            if (found) begin
                sb_q.push_back(x);
                m_ptr = (int'(x.src) + 1) % 3;
            end
            if (WD_EN) begin
                if (m_occ && !out_ready_i) begin
                    if (m_cnt < TO) begin
                        m_cnt++;
                        if (m_cnt == TO) m_to = 1'b1;
                    end
                end else begin
                    m_cnt = 0;
                end
                if (timeout_clr_i) m_to = 1'b0;
            end
            m_occ = found || (m_occ && !out_ready_i);
        end
    end

    // Monitor: compares whatever the DUT presents against the oldest expected transfer.
    always @(negedge clk_i) begin : monitor
        xfer_t e;
        if (rst_ni && out_valid_o) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb_q[0];
                check(out_ready_i ? "hs_addr" : "stall_addr", 64'(out_addr_o), 64'(e.addr));
                check(out_ready_i ? "hs_data" : "stall_data", out_data_o, e.data);
                check(out_ready_i ? "hs_src" : "stall_src", 64'(out_src_o), 64'(e.src));
                if (out_ready_i) void'(sb_q.pop_front());
            end
        end
    end

    task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid_i[i]         = 1'b1;
        req_addr_i[i*AW +: AW] = a;
        req_data_i[i*DW +: DW] = d;
    endtask

    task automatic post_rand(input int i);
        post(i, AW'($urandom), {$urandom, $urandom});
    endtask

    // Advance one cycle from posedge+1 to the next posedge+1, retiring accepted requests.
    task automatic step();
        logic [2:0] acc;
        @(negedge clk_i);
        acc = req_ready_o & req_valid_i;
        @(posedge clk_i);
        #1;
        req_valid_i = req_valid_i & ~acc;
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        steps(2);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 3'b000;
        req_addr_i    = '0;
        req_data_i    = '0;
        out_ready_i   = 1'b0;
        timeout_clr_i = 1'b0;
        @(posedge clk_i);
        #1;
        steps(2);
        rst_ni = 1'b1;

        // Idle after reset.
        steps(5);
        check("idle_ready", 64'(req_ready_o), 64'd0);
        check("idle_valid", 64'(out_valid_o), 64'd0);

        // Single CHI request.
        out_ready_i = 1'b1;
        post(1, 32'h2000, 64'h12345678_9ABCDEF0);
        #1;
        check("single_ready", 64'(req_ready_o), 64'b010);
        step();
        check("single_valid", 64'(out_valid_o), 64'd1);
        check("single_src", 64'(out_src_o), 64'd1);
        check("single_addr", 64'(out_addr_o), 64'h2000);
        check("single_data", out_data_o, 64'h12345678_9ABCDEF0);
        steps(3);

        // All three requesting continuously from a fresh pointer: 0,1,2,0,1,2 with no bubbles.
        do_reset();
        for (int n = 0; n < 9; n++) begin
            for (int i = 0; i < 3; i++) if (!req_valid_i[i]) post_rand(i);
            step();
        end
        steps(4);

        // TileLink accepted, then a 10-cycle downstream stall with other requesters waiting.
        out_ready_i = 1'b0;
        post_rand(2);
        step();
        for (int n = 0; n < 10; n++) begin
            if (n == 2) begin
                post_rand(0);
                post_rand(1);
            end
            step();
        end
        check("stall_ready_zero", 64'(req_ready_o), 64'd0);
        out_ready_i = 1'b1;
        steps(5);

        // 20-cycle stall for the watchdog, then handshake, then clear.
        out_ready_i = 1'b0;
        post_rand(0);
        steps(21);
        out_ready_i = 1'b1;
        steps(3);
        check("timeout_sticky", 64'(timeout_o), 64'(WD_EN));
        timeout_clr_i = 1'b1;
        step();
        timeout_clr_i = 1'b0;
        check("timeout_cleared", 64'(timeout_o), 64'd0);
        steps(2);

        // Reset while busy and stalled; held requests are re-arbitrated from pointer 0.
        out_ready_i = 1'b0;
        post_rand(1);
        steps(3);
        post_rand(1);
        post_rand(2);
        rst_ni = 1'b0;
        #1;
        check("rst_valid_now", 64'(out_valid_o), 64'd0);
        check("rst_ready_now", 64'(req_ready_o), 64'd0);
        steps(2);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check("post_rst_grant", 64'(req_ready_o), 64'b010);
        steps(4);

        // Randomised traffic with random backpressure and occasional timeout clears.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) if (!req_valid_i[i] && ($urandom_range(0, 2) == 0)) post_rand(i);
            out_ready_i   = ($urandom_range(0, 3) != 0) || (n % 200 > 170);
            if (n % 200 > 150 && n % 200 <= 170) out_ready_i = 1'b0;
            timeout_clr_i = ($urandom_range(0, 31) == 0);
            step();
        end
        timeout_clr_i = 1'b0;

        // Drain everything still pending.
        out_ready_i = 1'b1;
        steps(20);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("drained_valid", 64'(out_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
